// File: rtl/max7219_pkg.sv
// Shared MAX7219 frame definitions.
// Used by both the receiver and the transmitter.
package max7219_pkg;

    localparam logic [3:0] NOOP       = 4'h0;
    localparam logic [3:0] DIGIT0     = 4'h1;
    localparam logic [3:0] DECODE     = 4'h9;
    localparam logic [3:0] INTENSITY  = 4'hA;
    localparam logic [3:0] SCAN_LIMIT = 4'hB;
    localparam logic [3:0] SHUTDOWN   = 4'hC;
    localparam logic [3:0] TEST       = 4'hF;

    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        FRAME_SHORT,
        FRAME_OK,
        FRAME_LONG
    } frame_kind_e;

    function automatic frame_kind_e classify(input logic [4:0] cnt);
        if (cnt < 5'(FRAME_BITS))
            return FRAME_SHORT;
        else if (cnt == 5'(FRAME_BITS))
            return FRAME_OK;
        else
            return FRAME_LONG;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with registered edge strobes.
// rise/fall are single-cycle pulses one cycle after level changes.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    assign level = sync_q[STAGES-1];

    // Synchronize the pin and register its edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= level;
            rise   <= level & ~prev_q;
            fall   <= ~level & prev_q;
        end
    end

endmodule

// File: rtl/max7219_receiver.sv
// MAX7219-compatible serial receiver.
// Shifts 16-bit frames, latches them on LOAD, decodes registers.
module max7219_receiver
    import max7219_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_serial_din,
    input  logic        i_serial_clk,
    input  logic        i_serial_load,
    output logic        o_serial_dout,
    output logic        o_frame_stb,
    output logic        o_frame_err,
    output logic [3:0]  o_addr,
    output logic [7:0]  o_data,
    output logic [63:0] o_digits,
    output logic [7:0]  o_decode_mode,
    output logic [3:0]  o_intensity,
    output logic [2:0]  o_scan_limit,
    output logic        o_shutdown_n,
    output logic        o_display_test
);

    logic din_lvl, din_rise, din_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic load_lvl, load_rise, load_fall;
    logic unused_edges;

    logic [15:0] sr, sr_n;
    logic [4:0]  bit_cnt, cnt_n;
    logic        shift;
    logic [3:0]  addr_n;
    logic [7:0]  data_n;
    logic [2:0]  dig_idx;
    frame_kind_e kind;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_din (
        .clk(i_clk), .rst_n(i_reset_n), .d(i_serial_din),
        .level(din_lvl), .rise(din_rise), .fall(din_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(i_clk), .rst_n(i_reset_n), .d(i_serial_clk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_load (
        .clk(i_clk), .rst_n(i_reset_n), .d(i_serial_load),
        .level(load_lvl), .rise(load_rise), .fall(load_fall)
    );

    assign unused_edges = &{1'b0, din_rise, din_fall, sclk_lvl, load_fall};

    // Post-shift view of the frame, so a coincident load sees it.
    always_comb begin
        shift   = sclk_rise & ~load_lvl;
        sr_n    = sr;
        cnt_n   = bit_cnt;
        if (shift) begin
            sr_n = {sr[14:0], din_lvl};
            if (bit_cnt != 5'd31)
                cnt_n = bit_cnt + 5'd1;
        end
        kind    = classify(cnt_n);
        addr_n  = sr_n[11:8];
        data_n  = sr_n[7:0];
        dig_idx = 3'(addr_n - DIGIT0);
    end

    // Shift register, daisy-chain output and frame latch.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sr             <= '0;
            bit_cnt        <= '0;
            o_serial_dout  <= 1'b0;
            o_frame_stb    <= 1'b0;
            o_frame_err    <= 1'b0;
            o_addr         <= '0;
            o_data         <= '0;
            o_digits       <= '0;
            o_decode_mode  <= '0;
            o_intensity    <= '0;
            o_scan_limit   <= '0;
            o_shutdown_n   <= 1'b0;
            o_display_test <= 1'b0;
        end else begin
            o_frame_stb <= 1'b0;
            o_frame_err <= 1'b0;
            sr          <= sr_n;
            bit_cnt     <= load_rise ? 5'd0 : cnt_n;
            if (sclk_fall)
                o_serial_dout <= sr[15];
            if (load_rise) begin
                o_frame_err <= (kind != FRAME_OK);
                if (kind != FRAME_SHORT) begin
                    o_frame_stb <= 1'b1;
                    o_addr      <= addr_n;
                    o_data      <= data_n;
                    unique case (1'b1)
                        (addr_n >= DIGIT0 && addr_n <= DIGIT0 + 4'd7):
                            o_digits[{dig_idx, 3'b000} +: 8] <= data_n;
                        (addr_n == DECODE):
                            o_decode_mode <= data_n;
                        (addr_n == INTENSITY):
                            o_intensity <= data_n[3:0];
                        (addr_n == SCAN_LIMIT):
                            o_scan_limit <= data_n[2:0];
                        (addr_n == SHUTDOWN):
                            o_shutdown_n <= data_n[0];
                        (addr_n == TEST):
                            o_display_test <= data_n[0];
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_max7219_receiver.sv
// Directed bench for max7219_receiver.
// Drives the serial pins like a MAX7219 transmitter.
module tb_max7219_receiver;

    localparam int SYNC = 2;
    localparam int P    = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic        sclk = 1'b0;
    logic        load = 1'b0;
    logic        dout, stb, err;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [63:0] digits;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown_n, display_test;

    int n_chk  = 0;
    int n_pass = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    int s0, e0, lat;
    logic [31:0] dout_log = '0;

    max7219_receiver #(.SYNC_STAGES(SYNC)) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_serial_din(din),
        .i_serial_clk(sclk),
        .i_serial_load(load),
        .o_serial_dout(dout),
        .o_frame_stb(stb),
        .o_frame_err(err),
        .o_addr(addr),
        .o_data(data),
        .o_digits(digits),
        .o_decode_mode(decode_mode),
        .o_intensity(intensity),
        .o_scan_limit(scan_limit),
        .o_shutdown_n(shutdown_n),
        .o_display_test(display_test)
    );

    always #5 clk = ~clk;

    // Count strobe cycles away from the active edge.
    always @(negedge clk) begin
        if (stb) stb_cnt++;
        if (err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din = b;
        tick(P);
        dout_log = {dout_log[30:0], dout};
        sclk = 1'b1;
        tick(P);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--)
            send_bit(v[i]);
        tick(P);
    endtask

    task automatic pulse_load(output int l);
        load = 1'b1;
        l = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (l == 0 && (stb || err))
                l = i;
        end
        load = 1'b0;
        tick(P);
    endtask

    task automatic send_frame(input logic [3:0] a, input logic [7:0] d);
        send_bits({20'h0, a, d}, 16);
        pulse_load(lat);
    endtask

    function automatic logic [31:0] misc_outs();
        return {addr, data, decode_mode, intensity, scan_limit,
                shutdown_n, display_test, dout, stb, err};
    endfunction

    initial begin
        tick(3);
        chk("reset_misc", 64'(misc_outs()), 64'h0);
        chk("reset_digits", digits, 64'h0);
        rst_n = 1'b1;
        tick(3);

        s0 = stb_cnt; e0 = err_cnt;
        send_frame(4'hB, 8'h07);
        chk("latency", 64'(lat), 64'(SYNC + 2));
        send_frame(4'hA, 8'h07);
        send_frame(4'h9, 8'hFF);
        send_frame(4'hC, 8'h01);
        chk("scan_limit", 64'(scan_limit), 64'h7);
        chk("intensity", 64'(intensity), 64'h7);
        chk("decode_mode", 64'(decode_mode), 64'hFF);
        chk("shutdown_n", 64'(shutdown_n), 64'h1);
        chk("cfg_stb", 64'(stb_cnt - s0), 64'd4);
        chk("cfg_err", 64'(err_cnt - e0), 64'd0);

        send_frame(4'h3, 8'h05);
        chk("digit2", digits, 64'h0000_0000_0005_0000);
        chk("digit2_addr", 64'(addr), 64'h3);
        chk("digit2_data", 64'(data), 64'h05);

        s0 = stb_cnt; e0 = err_cnt;
        send_bits(32'hA05, 12);
        pulse_load(lat);
        chk("short_err", 64'(err_cnt - e0), 64'd1);
        chk("short_stb", 64'(stb_cnt - s0), 64'd0);
        chk("short_regs", {40'h0, addr, data, intensity, 8'h0},
            {40'h0, 4'h3, 8'h05, 4'h7, 8'h0});
        chk("short_digits", digits, 64'h0000_0000_0005_0000);

        send_frame(4'hC, 8'h00);
        chk("shutdown_off", 64'(shutdown_n), 64'h0);
        s0 = stb_cnt; e0 = err_cnt;
        send_bits(32'h0A0F_0C01, 32);
        pulse_load(lat);
        chk("long_shutdown", 64'(shutdown_n), 64'h1);
        chk("long_err", 64'(err_cnt - e0), 64'd1);
        chk("long_stb", 64'(stb_cnt - s0), 64'd1);
        chk("long_intensity", 64'(intensity), 64'h7);
        chk("long_dout", 64'(dout_log[15:0]), 64'h0A0F);

        s0 = stb_cnt;
        for (int k = 0; k < 8; k++)
            send_frame(4'(k + 1), 8'(8'hA1 + k));
        chk("all_digits", digits, 64'hA8A7_A6A5_A4A3_A2A1);
        chk("all_stb", 64'(stb_cnt - s0), 64'd8);

        send_bits(32'h0C, 8);
        rst_n = 1'b0;
        tick(2);
        chk("midrst_misc", 64'(misc_outs()), 64'h0);
        chk("midrst_digits", digits, 64'h0);
        rst_n = 1'b1;
        tick(3);
        s0 = stb_cnt; e0 = err_cnt;
        pulse_load(lat);
        chk("midrst_err", 64'(err_cnt - e0), 64'd1);
        chk("midrst_stb", 64'(stb_cnt - s0), 64'd0);
        chk("midrst_shutdown", 64'(shutdown_n), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
